// File: rtl/hood_mode_ctrl_if.sv
// hood_mode_ctrl_if
//   Groups the button/power inputs and the mode outputs of the hood mode
//   sequencer so they travel as one port.
//   master : drives machine_state and button pulses, observes mode outputs
//   slave  : the sequencer itself (consumes buttons, drives mode outputs)
interface hood_mode_ctrl_if;
    logic       machine_state;
    logic       menu_btn;
    logic       mode1_btn;
    logic       mode2_btn;
    logic       mode3_btn;
    logic       mode_self_clean_btn;
    logic [2:0] mode_state;
    logic [7:0] countdown;
    logic       count_active;
    logic       hurricane_used;
    logic [4:0] led;

    modport master (
        output machine_state, menu_btn, mode1_btn, mode2_btn, mode3_btn,
               mode_self_clean_btn,
        input  mode_state, countdown, count_active, hurricane_used, led
    );

    modport slave (
        input  machine_state, menu_btn, mode1_btn, mode2_btn, mode3_btn,
               mode_self_clean_btn,
        output mode_state, countdown, count_active, hurricane_used, led
    );
endinterface

// File: rtl/hood_mode_ctrl.sv
// hood_mode_ctrl
//   Mode sequencer for the kitchen hood. Turns debounced button pulses into
//   mode transitions behind a menu gate, runs the timed hurricane / run-on /
//   self-clean states from a one-second prescaler.
//   clk  : system clock
//   rst  : synchronous active-low reset
//   bus  : hood_mode_ctrl_if.slave (power + buttons in, mode_state,
//          countdown, count_active, hurricane_used, led out; all registered)
module hood_mode_ctrl #(
    parameter int TICKS_PER_SEC = 100_000_000,
    parameter int HURRICANE_SEC = 60,
    parameter int RETURN_SEC    = 60,
    parameter int CLEAN_SEC     = 180
) (
    input logic              clk,
    input logic              rst,
    hood_mode_ctrl_if.slave  bus
);
    localparam logic [2:0] S_STANDBY   = 3'd0;
    localparam logic [2:0] S_MODE1     = 3'd1;
    localparam logic [2:0] S_MODE2     = 3'd2;
    localparam logic [2:0] S_HURRICANE = 3'd3;
    localparam logic [2:0] S_RETURN    = 3'd4;
    localparam logic [2:0] S_CLEAN     = 3'd5;

    localparam int         PW       = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [7:0] H_LOAD   = 8'(HURRICANE_SEC);
    localparam logic [7:0] R_LOAD   = 8'(RETURN_SEC);
    localparam logic [7:0] C_LOAD   = 8'(CLEAN_SEC);

    logic [2:0]    state_q, state_d;
    logic          menu_open_q, menu_open_d;
    logic [7:0]    countdown_q, countdown_d;
    logic          used_q, used_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    mode_state_q, mode_state_d;
    logic [4:0]    led_q, led_d;
    logic          active_q, active_d;

    logic timed_q, tick;
    logic win_menu, win_m3, win_m2, win_m1, win_clean;

    assign timed_q = (state_q == S_HURRICANE) || (state_q == S_RETURN) || (state_q == S_CLEAN);
    assign tick    = timed_q && (presc_q == PRESC_LAST);

    // Fixed priority: only the highest-priority pulse is ever evaluated, so an
    // ignored winner masks any lower pulse in the same cycle.
    assign win_menu  = bus.menu_btn;
    assign win_m3    = !bus.menu_btn && bus.mode3_btn;
    assign win_m2    = !bus.menu_btn && !bus.mode3_btn && bus.mode2_btn;
    assign win_m1    = !bus.menu_btn && !bus.mode3_btn && !bus.mode2_btn && bus.mode1_btn;
    assign win_clean = !bus.menu_btn && !bus.mode3_btn && !bus.mode2_btn && !bus.mode1_btn
                       && bus.mode_self_clean_btn;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d     = state_q;
        menu_open_d = menu_open_q;
        countdown_d = countdown_q;
        used_d      = used_q;
        presc_d     = '0;
        if (timed_q) presc_d = tick ? '0 : presc_q + PW'(1);

        if (!bus.machine_state) begin
            state_d     = S_STANDBY;
            menu_open_d = 1'b0;
            countdown_d = '0;
            used_d      = 1'b0;
            presc_d     = '0;
        end else begin
            case (state_q)
                S_STANDBY: begin
                    if (win_menu) begin
                        menu_open_d = !menu_open_q;
                    end else if (menu_open_q) begin
                        if (win_m3 && !used_q) begin
                            state_d = S_HURRICANE; used_d = 1'b1;
                            countdown_d = H_LOAD; menu_open_d = 1'b0;
                        end else if (win_m2) begin
                            state_d = S_MODE2; menu_open_d = 1'b0;
                        end else if (win_m1) begin
                            state_d = S_MODE1; menu_open_d = 1'b0;
                        end else if (win_clean) begin
                            state_d = S_CLEAN; countdown_d = C_LOAD; menu_open_d = 1'b0;
                        end
                    end
                end
                S_MODE1, S_MODE2: begin
                    if (win_menu) begin
                        state_d = S_STANDBY;
                    end else if (win_m3 && !used_q) begin
                        state_d = S_HURRICANE; used_d = 1'b1; countdown_d = H_LOAD;
                    end else if (win_m2) begin
                        state_d = S_MODE2;
                    end else if (win_m1) begin
                        state_d = S_MODE1;
                    end
                end
                S_HURRICANE: begin
                    // Menu beats a simultaneous expiry and restarts the second.
                    if (win_menu) begin
                        state_d = S_RETURN; countdown_d = R_LOAD; presc_d = '0;
                    end else if (tick) begin
                        if (countdown_q == 8'd1) begin
                            state_d = S_MODE2; countdown_d = '0;
                        end else begin
                            countdown_d = countdown_q - 8'd1;
                        end
                    end
                end
                S_RETURN, S_CLEAN: begin
                    if (tick) begin
                        if (countdown_q == 8'd1) begin
                            state_d = S_STANDBY; countdown_d = '0;
                        end else begin
                            countdown_d = countdown_q - 8'd1;
                        end
                    end
                end
                default: begin
                    state_d = S_STANDBY; countdown_d = '0; menu_open_d = 1'b0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they land on the same edge
    // as the state change, with no extra cycle of latency.
    always_comb begin
        case (state_d)
            S_MODE1:               mode_state_d = 3'b001;
            S_MODE2:               mode_state_d = 3'b010;
            S_HURRICANE, S_RETURN: mode_state_d = 3'b011;
            S_CLEAN:               mode_state_d = 3'b100;
            default:               mode_state_d = 3'b000;
        endcase
        active_d = (state_d == S_HURRICANE) || (state_d == S_RETURN) || (state_d == S_CLEAN);
        led_d    = {menu_open_d,
                    state_d == S_CLEAN,
                    (state_d == S_HURRICANE) || (state_d == S_RETURN),
                    state_d == S_MODE2,
                    state_d == S_MODE1};
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_STANDBY;
            menu_open_q  <= 1'b0;
            countdown_q  <= '0;
            used_q       <= 1'b0;
            presc_q      <= '0;
            mode_state_q <= '0;
            led_q        <= '0;
            active_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            menu_open_q  <= menu_open_d;
            countdown_q  <= countdown_d;
            used_q       <= used_d;
            presc_q      <= presc_d;
            mode_state_q <= mode_state_d;
            led_q        <= led_d;
            active_q     <= active_d;
        end
    end

    assign bus.mode_state     = mode_state_q;
    assign bus.countdown      = countdown_q;
    assign bus.count_active   = active_q;
    assign bus.hurricane_used = used_q;
    assign bus.led            = led_q;
endmodule

// File: tb/tb_hood_mode_ctrl.sv
// tb_hood_mode_ctrl
//   Scoreboard bench for hood_mode_ctrl. The driver applies one cycle of
//   stimulus, steps a cycle-count reference model and queues the expected
//   outputs; an independent monitor pops and compares after each edge.
module tb_hood_mode_ctrl;
    localparam int T = 4;
    localparam int H = 3;
    localparam int R = 2;
    localparam int C = 5;

    localparam logic [4:0] B_NONE = 5'b00000;
    localparam logic [4:0] B_MENU = 5'b00001;
    localparam logic [4:0] B_M1   = 5'b00010;
    localparam logic [4:0] B_M2   = 5'b00100;
    localparam logic [4:0] B_M3   = 5'b01000;
    localparam logic [4:0] B_CL   = 5'b10000;

    typedef enum int {M_STANDBY, M_MODE1, M_MODE2, M_HURRICANE, M_RETURN, M_CLEAN} mmode_t;

    typedef struct {
        logic [2:0] mode_state;
        logic [7:0] countdown;
        logic       count_active;
        logic       hurricane_used;
        logic [4:0] led;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    hood_mode_ctrl_if bus();

    hood_mode_ctrl #(
        .TICKS_PER_SEC(T), .HURRICANE_SEC(H), .RETURN_SEC(R), .CLEAN_SEC(C)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    exp_t exp_q[$];

    // Reference model: mode plus cycles left in the current timed state.
    mmode_t m_mode = M_STANDBY;
    bit     m_menu = 1'b0;
    bit     m_used = 1'b0;
    int     m_left = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic enter_timed(input mmode_t m, input int secs);
        m_mode = m;
        m_left = secs * T;
    endtask

    task automatic model_step(input bit rst_v, input bit ms, input logic [4:0] b);
        int   win;
        exp_t e;
        bit   timed;
        if (!rst_v || !ms) begin
            m_mode = M_STANDBY; m_menu = 0; m_used = 0; m_left = 0;
        end else begin
            win = b[0] ? 1 : b[3] ? 3 : b[2] ? 2 : b[1] ? 4 : b[4] ? 5 : 0;
            case (m_mode)
                M_STANDBY: begin
                    if (win == 1) m_menu = !m_menu;
                    else if (m_menu) begin
                        if (win == 3 && !m_used) begin
                            enter_timed(M_HURRICANE, H); m_used = 1; m_menu = 0;
                        end else if (win == 2) begin m_mode = M_MODE2; m_menu = 0; end
                        else if (win == 4) begin m_mode = M_MODE1; m_menu = 0; end
                        else if (win == 5) begin enter_timed(M_CLEAN, C); m_menu = 0; end
                    end
                end
                M_MODE1, M_MODE2: begin
                    if (win == 1) m_mode = M_STANDBY;
                    else if (win == 3 && !m_used) begin enter_timed(M_HURRICANE, H); m_used = 1; end
                    else if (win == 2) m_mode = M_MODE2;
                    else if (win == 4) m_mode = M_MODE1;
                end
                M_HURRICANE: begin
                    if (win == 1) enter_timed(M_RETURN, R);
                    else begin
                        m_left--;
                        if (m_left == 0) m_mode = M_MODE2;
                    end
                end
                default: begin
                    m_left--;
                    if (m_left == 0) m_mode = M_STANDBY;
                end
            endcase
        end
        timed = (m_mode == M_HURRICANE) || (m_mode == M_RETURN) || (m_mode == M_CLEAN);
        e.mode_state     = (m_mode == M_HURRICANE || m_mode == M_RETURN) ? 3'd3 :
                           (m_mode == M_CLEAN) ? 3'd4 : 3'(int'(m_mode));
        e.countdown      = timed ? 8'((m_left + T - 1) / T) : 8'd0;
        e.count_active   = timed;
        e.hurricane_used = m_used;
        e.led            = {m_menu && m_mode == M_STANDBY, m_mode == M_CLEAN,
                            m_mode == M_HURRICANE || m_mode == M_RETURN,
                            m_mode == M_MODE2, m_mode == M_MODE1};
        exp_q.push_back(e);
    endtask

    // One clock cycle of stimulus; inputs change on the falling edge.
    task automatic step(input bit rst_v, input bit ms, input logic [4:0] b);
        @(negedge clk);
        rst                     = rst_v;
        bus.machine_state       = ms;
        bus.menu_btn            = b[0];
        bus.mode1_btn           = b[1];
        bus.mode2_btn           = b[2];
        bus.mode3_btn           = b[3];
        bus.mode_self_clean_btn = b[4];
        model_step(rst_v, ms, b);
        @(posedge clk);
    endtask

    task automatic press(input logic [4:0] b);
        step(1'b1, 1'b1, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) press(B_NONE);
    endtask

    // Monitor: outputs are valid every cycle; compare one entry per edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("mode_state",     16'(bus.mode_state),     16'(e.mode_state));
                check("countdown",      16'(bus.countdown),      16'(e.countdown));
                check("count_active",   16'(bus.count_active),   16'(e.count_active));
                check("hurricane_used", 16'(bus.hurricane_used), 16'(e.hurricane_used));
                check("led",            16'(bus.led),            16'(e.led));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] b;
        bit         ms;
        bit         rv;
        bus.machine_state       = 1'b0;
        bus.menu_btn            = 1'b0;
        bus.mode1_btn           = 1'b0;
        bus.mode2_btn           = 1'b0;
        bus.mode3_btn           = 1'b0;
        bus.mode_self_clean_btn = 1'b0;

        step(1'b0, 1'b1, B_NONE);
        step(1'b0, 1'b1, B_NONE);
        idle(2);

        // Menu gate, then mode2.
        press(B_M1); idle(2);
        press(B_MENU); press(B_M2); idle(2);

        // Hurricane runs out to mode2, then is refused for the session.
        press(B_MENU); press(B_M3); idle(14);
        press(B_MENU); press(B_MENU); press(B_M3); idle(2); press(B_MENU);

        // Fresh session: hurricane left via menu into the run-on.
        step(1'b1, 1'b0, B_NONE); idle(1);
        press(B_MENU); press(B_M3); idle(4); press(B_MENU); idle(10);

        // Self-clean ignores everything until it expires.
        press(B_MENU); press(B_CL); idle(3);
        press(B_MENU); press(B_M1); press(B_M3); idle(16);

        // Same-cycle menu + mode3 in MODE1: menu wins.
        press(B_MENU); press(B_M1); press(B_MENU | B_M3); idle(2);

        // Power drop mid-hurricane.
        step(1'b1, 1'b0, B_NONE); idle(1);
        press(B_MENU); press(B_M3); idle(6);
        step(1'b1, 1'b0, B_NONE); idle(2);

        // Reset mid-clean, then hurricane is available again.
        press(B_MENU); press(B_CL); idle(5);
        step(1'b0, 1'b1, B_NONE);
        press(B_MENU); press(B_M3); idle(3);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            b  = B_NONE;
            for (int k = 0; k < 5; k++) b[k] = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0) b[0] = ($urandom_range(0, 2) == 0);
            ms = ($urandom_range(0, 249) != 0);
            rv = ($urandom_range(0, 399) != 0);
            step(rv, ms, b);
        end

        @(negedge clk);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/hood_mode_ctrl.md
# hood_mode_ctrl

Mode sequencer for the kitchen-hood controller. It owns the 3-bit `mode_state` consumed by the smoker and self-cleaner datapaths. It turns debounced button pulses into mode transitions, with these rules:
- a menu gate before any mode can be entered,
- hurricane (mode 3) allowed once per power-on session, with timed fall-back and timed exit,
- a timed, non-abortable self-clean.

It sits between the on/off control (`machine_state`) and the mode datapaths, and replaces ad-hoc mode decoding in the top level.

## Interface
- `TICKS_PER_SEC`, 100_000_000: clk cycles per countdown second.
- `HURRICANE_SEC`, 60: mode-3 run time before automatic drop to mode 2 (1..255).
- `RETURN_SEC`, 60: fan run-on after leaving mode 3 via menu (1..255).
- `CLEAN_SEC`, 180: self-clean duration (1..255).

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-low reset.
- `machine_state`  in  1  1 = powered on; from on/off control.
- `menu_btn`  in  1  single-cycle pulse, debounced upstream.
- `mode1_btn`, `mode2_btn`, `mode3_btn`, `mode_self_clean_btn`  in  1 each  single-cycle pulses.
- `mode_state`  out  3  000 standby, 001 mode1, 010 mode2, 011 mode3, 100 self-clean.
- `countdown`  out  8  seconds remaining in the current timed state; 0 otherwise.
- `count_active`  out  1  high in HURRICANE, RETURN, CLEAN.
- `hurricane_used`  out  1  mode 3 already entered this session.
- `led`  out  5  [0] mode1, [1] mode2, [2] mode3/return, [3] clean, [4] menu_open.

## Operation
- Internal states: STANDBY, MODE1, MODE2, HURRICANE, RETURN, CLEAN. There is also a `menu_open` flag, meaningful only in STANDBY.
- `mode_state` mapping: STANDBY 000, MODE1 001, MODE2 010, HURRICANE 011, RETURN 011, CLEAN 100.
- `machine_state`=0 overrides everything. It forces STANDBY and clears `menu_open`, `countdown`, the prescaler and `hurricane_used`. It applies in any state, mid-countdown included.
- STANDBY:
  - `menu_btn` toggles `menu_open`.
  - With `menu_open`=1:
    - mode1 → MODE1; mode2 → MODE2.
    - mode3 → HURRICANE if `hurricane_used`=0, else ignored.
    - clean → CLEAN.
  - Any accepted selection clears `menu_open`.
  - With `menu_open`=0, mode buttons are ignored.
- MODE1/MODE2:
  - mode1/mode2 switch directly between them.
  - mode3 → HURRICANE if not used.
  - `menu_btn` → STANDBY.
  - clean is ignored.
- HURRICANE:
  - Entry sets `hurricane_used`=1 and loads `countdown`=HURRICANE_SEC.
  - Countdown expiry → MODE2.
  - `menu_btn` → RETURN with `countdown`=RETURN_SEC.
  - Other buttons are ignored.
- RETURN: all buttons are ignored; expiry → STANDBY.
- CLEAN: `countdown`=CLEAN_SEC; all buttons, including menu, are ignored; expiry → STANDBY.
- Simultaneous pulses in one cycle: priority is menu > mode3 > mode2 > mode1 > clean. Only the winner is evaluated. If the winner is ignored in the current state, nothing happens that cycle.
- `hurricane_used` is cleared only by reset or power-off.

## Timing
- Reset (`rst`=0 at a clk edge): STANDBY, `menu_open`=0, `mode_state`=000, `countdown`=0, `count_active`=0, `hurricane_used`=0, `led`=00000, prescaler=0.
- A button pulse sampled at edge k changes the state at edge k. Outputs are registered and reflect the new state from that edge on, so there is 1-cycle latency from pulse to `mode_state`.
- Prescaler:
  - Counts 0..TICKS_PER_SEC-1 only in timed states.
  - Reset to 0 on every state entry.
  - Tick asserts when it wraps.
  - First tick comes TICKS_PER_SEC cycles after entry.
- On each tick, `countdown` decrements.
- If a tick occurs with `countdown`=1, the state change and the next load happen at the same edge. `countdown` never shows 0 inside a timed state. A timed state therefore lasts exactly N×TICKS_PER_SEC cycles.
- HURRICANE→RETURN on menu reloads `countdown` and restarts the prescaler at that edge.
- `countdown` is 0 and `count_active` is 0 at the same edge the FSM enters any untimed state.
- `led` is a registered, direct decode of state and `menu_open`; it has no extra latency versus `mode_state`.

## Test plan
(`TICKS_PER_SEC`=4, `HURRICANE_SEC`=3, `RETURN_SEC`=2, `CLEAN_SEC`=5)
- Reset, then mode1 pulse with menu closed → `mode_state` stays 000. Then menu, mode2 → 010, `led`=00010, `menu_open` cleared.
- Menu, mode3 → 011, `countdown`=3, `hurricane_used`=1. After 12 cycles → 010, `countdown`=0. Then menu → 000; menu, mode3 → stays 000 with `menu_open`=1.
- Enter HURRICANE; after 5 cycles pulse menu → `mode_state` 011, `countdown`=2. Exactly 8 cycles later → 000.
- Menu, clean → 100, `countdown` 5→1 at 4-cycle spacing. Menu/mode pulses mid-clean are ignored. At cycle 20 → 000.
- In MODE1, pulse menu and mode3 in the same cycle → STANDBY (menu wins). In HURRICANE with `countdown`=2, drop `machine_state` → 000, `countdown`=0, `hurricane_used`=0.
- Assert `rst`=0 mid-CLEAN for 1 cycle → all outputs at reset values on the next edge. Then menu, mode3 is accepted.
